// File: rtl/ifu_mem_ctrl.sv
// Fetch controller: one read per PC, result handed to decode on valid/ready; 4 cycles/instr at zero wait.
// Stalls on arready/rvalid/inst_ready hold state; flushes drain the in-flight read and drop its data.
module ifu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              fetch_en,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                err_q, err_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                ivalid_q, ivalid_d;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    araddr_d  = araddr_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    err_d     = err_q;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    ivalid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        // A flush means pc is mid-update, so sampling it now would fetch a stale target.
        if (!flush) begin
          araddr_d  = pc;
          inst_pc_d = pc;
          if (pc[1:0] != 2'b00) begin
            inst_d   = '0;
            err_d    = 1'b1;
            state_d  = S_OUT;
            ivalid_d = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_AR: begin
        if (flush) drop_d = 1'b1;
        if (mem_arready) begin
          state_d  = S_R;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      S_R: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          if (drop_q || flush) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end else begin
            inst_d   = mem_rdata;
            err_d    = (mem_rresp != 2'b00);
            state_d  = S_OUT;
            ivalid_d = 1'b1;
          end
        end else begin
          rready_d = 1'b1;
        end
      end

      S_OUT: begin
        if (flush || inst_ready) begin
          state_d = S_IDLE;
        end else begin
          ivalid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      drop_q    <= 1'b0;
      araddr_q  <= '0;
      inst_pc_q <= '0;
      inst_q    <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ivalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      araddr_q  <= araddr_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ivalid_q  <= ivalid_d;
    end
  end

  // Flush wins over the decode handshake so a redirected PC never gets advanced twice.
  assign fetch_en    = (state_q == S_OUT) && inst_ready && !flush;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = rready_q;
  assign inst_valid  = ivalid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_err    = err_q;

endmodule
